// File: rtl/pcie_msg_pkg.sv
// Shared types and constants for the PCIe message-queue drain scheduler.
package pcie_msg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    CLEAR  = 3'd4,
    SETTLE = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         PCIE_4KB       = 4096;

endpackage

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module pcie_rr_arbiter #(
  parameter int NUM_Q = 15,
  parameter int QW    = 4
) (
  input  logic [NUM_Q-1:0] i_req,
  input  logic [QW-1:0]    i_ptr,
  output logic [NUM_Q-1:0] o_grant,
  output logic [QW-1:0]    o_idx,
  output logic             o_valid
);

  int            j;
  logic [QW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    w_j     = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      j = int'(i_ptr) + i;
      if (j >= NUM_Q) j = j - NUM_Q;
      w_j = QW'(j);
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_idx      = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_msg_q_drain_sched.sv
// Round-robin drain of pending SRAM message queues via AXI read bursts.
// Optional watchdog abort enabled by defining PCIE_DRAIN_TIMEOUT_EN.
module pcie_msg_q_drain_sched
  import pcie_msg_pkg::*;
#(
  parameter int NUM_Q       = 15,
  parameter int ADDR_W      = 32,
  parameter int BEAT_BYTES  = 32,
  parameter int MAX_BURST   = 16,
  parameter int QLEN_W      = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic [NUM_Q-1:0]        i_q_intr_status,
  input  logic [NUM_Q*ADDR_W-1:0] i_q_init_addr,
  input  logic [NUM_Q*QLEN_W-1:0] i_q_len,
  output logic [NUM_Q-1:0]        o_q_intr_clear,
  output logic [6:0]              o_arid,
  output logic [ADDR_W-1:0]       o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [255:0]            i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  output logic                    o_sink_valid,
  output logic [255:0]            o_sink_data,
  output logic                    o_sink_last,
  output logic [3:0]              o_sink_q,
  input  logic                    i_sink_ready,
  output logic                    o_done_valid,
  output logic [3:0]              o_done_q,
  output logic                    o_done_err,
  output logic                    o_busy
`ifdef PCIE_DRAIN_TIMEOUT_EN
  ,
  output logic                    o_timeout
`endif
);

  localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int BW = 9;

  state_e              r_state;
  logic [QW-1:0]       r_rr_ptr;
  logic [QW-1:0]       r_q;
  logic [ADDR_W-1:0]   r_addr;
  logic [QLEN_W-1:0]   r_remain;
  logic [BW-1:0]       r_beats;
  logic [BW-1:0]       r_bcnt;
  logic                r_err;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [NUM_Q-1:0]    r_intr_clear;
  logic                r_done_valid;
  logic                r_done_err;
  logic                r_busy;

  logic [NUM_Q-1:0]    w_grant;
  logic [QW-1:0]       w_gidx;
  logic                w_gvalid;
  logic [ADDR_W-1:0]   w_q_addr;
  logic [QLEN_W-1:0]   w_q_len;
  logic [BW-1:0]       w_beats_arb;
  logic [BW-1:0]       w_beats_nxt;
  logic [QLEN_W-1:0]   w_remain_dec;
  logic [ADDR_W-1:0]   w_addr_next;
  logic                w_burst_end;
  logic                w_beat_err;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_to_hit;
  logic [NUM_Q-1:0]    w_q_onehot;

  // Burst size limited by remaining beats, MAX_BURST and the 4 KB page; an
  // unaligned tail smaller than one beat still issues a single beat.
  function automatic logic [BW-1:0] f_beats(input logic [11:0] off,
                                            input logic [QLEN_W-1:0] rem);
    int b;
    int room;
    room = (PCIE_4KB - int'(off)) / BEAT_BYTES;
    b    = int'(rem);
    if (b > MAX_BURST) b = MAX_BURST;
    if (b > room)      b = room;
    if (b < 1)         b = 1;
    return BW'(b);
  endfunction

  pcie_rr_arbiter #(.NUM_Q(NUM_Q), .QW(QW)) u_arb (
    .i_req   (i_q_intr_status),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  assign w_q_addr     = i_q_init_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
  assign w_q_len      = i_q_len[int'(w_gidx)*QLEN_W +: QLEN_W];
  assign w_ar_hs      = r_arvalid & i_arready;
  assign w_r_hs       = (r_state == DATA) & i_rvalid & i_sink_ready;
  assign w_remain_dec = r_remain - QLEN_W'(1);
  assign w_burst_end  = (r_bcnt == r_beats - BW'(1));
  assign w_addr_next  = r_addr + (ADDR_W'(r_beats) * ADDR_W'(BEAT_BYTES));
  assign w_beat_err   = (i_rresp != AXI_RESP_OKAY) | (i_rlast != w_burst_end);
  assign w_beats_arb  = f_beats(w_q_addr[11:0], w_q_len);
  assign w_beats_nxt  = f_beats(w_addr_next[11:0], w_remain_dec);
  assign w_q_onehot   = NUM_Q'(1) << r_q;

`ifdef PCIE_DRAIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_to_hit = ((r_state == ADDR) || (r_state == DATA)) && !w_ar_hs && !w_r_hs &&
                    (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (((r_state == ADDR) || (r_state == DATA)) && !w_ar_hs && !w_r_hs)
        r_to_cnt <= r_to_cnt + TW'(1);
      else
        r_to_cnt <= '0;
      if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_q          <= '0;
      r_addr       <= '0;
      r_remain     <= '0;
      r_beats      <= '0;
      r_bcnt       <= '0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_intr_clear <= '0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_intr_clear <= '0;
      r_done_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_enable && |i_q_intr_status) begin
            r_state <= ARB;
            r_busy  <= 1'b1;
          end
        end
        ARB: begin
          if (w_gvalid) begin
            r_q      <= w_gidx;
            r_addr   <= w_q_addr;
            r_remain <= w_q_len;
            r_err    <= 1'b0;
            r_rr_ptr <= (w_gidx == QW'(NUM_Q - 1)) ? '0 : w_gidx + QW'(1);
            if (w_q_len == '0) begin
              r_state      <= CLEAR;
              r_intr_clear <= w_grant;
              r_done_valid <= 1'b1;
              r_done_err   <= 1'b0;
            end else begin
              r_state   <= ADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_q_addr;
              r_arlen   <= 8'(w_beats_arb - BW'(1));
              r_beats   <= w_beats_arb;
            end
          end else begin
            // Status dropped between IDLE and ARB: nothing to serve.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ADDR: begin
          if (w_to_hit) begin
            r_arvalid    <= 1'b0;
            r_state      <= CLEAR;
            r_intr_clear <= w_q_onehot;
            r_done_valid <= 1'b1;
            r_done_err   <= 1'b1;
          end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_bcnt    <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_r_hs) begin
            r_remain <= w_remain_dec;
            r_err    <= r_err | w_beat_err;
            r_bcnt   <= r_bcnt + BW'(1);
            // The beat count, not rlast, closes the burst.
            if (w_burst_end) begin
              r_addr <= w_addr_next;
              if (w_remain_dec == '0) begin
                r_state      <= CLEAR;
                r_intr_clear <= w_q_onehot;
                r_done_valid <= 1'b1;
                r_done_err   <= r_err | w_beat_err;
              end else begin
                r_state   <= ADDR;
                r_arvalid <= 1'b1;
                r_araddr  <= w_addr_next;
                r_arlen   <= 8'(w_beats_nxt - BW'(1));
                r_beats   <= w_beats_nxt;
              end
            end
          end else if (w_to_hit) begin
            r_state      <= CLEAR;
            r_intr_clear <= w_q_onehot;
            r_done_valid <= 1'b1;
            r_done_err   <= 1'b1;
          end
        end
        CLEAR: r_state <= SETTLE;
        SETTLE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_q_intr_clear = r_intr_clear;
  assign o_arid         = 7'(r_q);
  assign o_araddr       = r_araddr;
  assign o_arlen        = r_arlen;
  assign o_arsize       = 3'($clog2(BEAT_BYTES));
  assign o_arburst      = AXI_BURST_INCR;
  assign o_arvalid      = r_arvalid;
  assign o_rready       = (r_state == DATA) & i_sink_ready;
  assign o_sink_valid   = (r_state == DATA) & i_rvalid;
  assign o_sink_data    = i_rdata;
  assign o_sink_last    = (r_state == DATA) && (r_remain == QLEN_W'(1));
  assign o_sink_q       = 4'(r_q);
  assign o_done_valid   = r_done_valid;
  assign o_done_q       = 4'(r_q);
  assign o_done_err     = r_done_err;
  assign o_busy         = r_busy;

endmodule
